// File: rtl/wb_stage.sv
// Write-back stage: MEM/WB pipeline register with stall/flush, load data formatting,
// write-back source select, register-file write port and retired-instruction counter.
module wb_stage #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    input  logic                          stall,
    input  logic                          flush,
    input  logic [XLEN-1:0]               alu,
    input  logic [XLEN-1:0]               dataB,
    input  logic [XLEN-1:0]               pc_4,
    input  logic [XLEN-1:0]               imm,
    input  logic [1:0]                    WBSel,
    input  logic [2:0]                    funct3,
    input  logic [$clog2(XLEN/8)-1:0]     addr_lo,
    input  logic [4:0]                    rd,
    input  logic                          RegWEn,
    output logic [XLEN-1:0]               wb,
    output logic [4:0]                    wb_rd,
    output logic                          wb_we,
    output logic                          wb_valid,
    output logic [CNT_W-1:0]              retired
);

    localparam int AW = $clog2(XLEN/8);

    logic              valid_q,   valid_d;
    logic [XLEN-1:0]   alu_q,     alu_d;
    logic [XLEN-1:0]   data_q,    data_d;
    logic [XLEN-1:0]   pc4_q,     pc4_d;
    logic [XLEN-1:0]   imm_q,     imm_d;
    logic [1:0]        wbsel_q,   wbsel_d;
    logic [2:0]        funct3_q,  funct3_d;
    logic [AW-1:0]     addr_lo_q, addr_lo_d;
    logic [4:0]        rd_q,      rd_d;
    logic              regwen_q,  regwen_d;
    logic [CNT_W-1:0]  retired_q, retired_d;

    // Flush only kills the incoming instruction, so the counter still sees the outgoing one.
    always_comb begin
        valid_d   = valid_q;
        alu_d     = alu_q;
        data_d    = data_q;
        pc4_d     = pc4_q;
        imm_d     = imm_q;
        wbsel_d   = wbsel_q;
        funct3_d  = funct3_q;
        addr_lo_d = addr_lo_q;
        rd_d      = rd_q;
        regwen_d  = regwen_q;
        retired_d = retired_q + CNT_W'(valid_q && !stall);
        if (flush) begin
            valid_d = 1'b0;
        end else if (!stall) begin
            valid_d   = in_valid;
            alu_d     = alu;
            data_d    = dataB;
            pc4_d     = pc_4;
            imm_d     = imm;
            wbsel_d   = WBSel;
            funct3_d  = funct3;
            addr_lo_d = addr_lo;
            rd_d      = rd;
            regwen_d  = RegWEn;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q   <= 1'b0;
            alu_q     <= '0;
            data_q    <= '0;
            pc4_q     <= '0;
            imm_q     <= '0;
            wbsel_q   <= '0;
            funct3_q  <= '0;
            addr_lo_q <= '0;
            rd_q      <= '0;
            regwen_q  <= 1'b0;
            retired_q <= '0;
        end else begin
            valid_q   <= valid_d;
            alu_q     <= alu_d;
            data_q    <= data_d;
            pc4_q     <= pc4_d;
            imm_q     <= imm_d;
            wbsel_q   <= wbsel_d;
            funct3_q  <= funct3_d;
            addr_lo_q <= addr_lo_d;
            rd_q      <= rd_d;
            regwen_q  <= regwen_d;
            retired_q <= retired_d;
        end
    end

    logic [AW-1:0]   lane;
    logic [7:0]      ld_byte;
    logic [15:0]     ld_half;
    logic [31:0]     ld_word;
    logic [XLEN-1:0] ld_data;
    logic [XLEN-1:0] wb_src;

    // Lane is forced down to the access alignment; a dword always starts at lane 0.
    always_comb begin
        lane = addr_lo_q;
        case (funct3_q[1:0])
            2'b01:   lane = addr_lo_q & ~AW'(1);
            2'b10:   lane = addr_lo_q & ~AW'(3);
            2'b11:   lane = '0;
            default: lane = addr_lo_q;
        endcase
        ld_byte = 8'(data_q >> {lane, 3'b000});
        ld_half = 16'(data_q >> {lane, 3'b000});
        ld_word = 32'(data_q >> {lane, 3'b000});
        case (funct3_q)
            3'b000:  ld_data = XLEN'($signed(ld_byte));
            3'b100:  ld_data = XLEN'(ld_byte);
            3'b001:  ld_data = XLEN'($signed(ld_half));
            3'b101:  ld_data = XLEN'(ld_half);
            3'b010:  ld_data = XLEN'($signed(ld_word));
            3'b110:  ld_data = XLEN'(ld_word);
            default: ld_data = data_q;
        endcase
    end

    always_comb begin
        case (wbsel_q)
            2'b01:   wb_src = alu_q;
            2'b10:   wb_src = pc4_q;
            2'b11:   wb_src = imm_q;
            default: wb_src = ld_data;
        endcase
    end

    assign wb       = valid_q ? wb_src : '0;
    assign wb_rd    = valid_q ? rd_q : 5'd0;
    assign wb_we    = valid_q & regwen_q & (rd_q != 5'd0);
    assign wb_valid = valid_q;
    assign retired  = retired_q;

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: a 32-bit instance (4-bit counter) and a 64-bit
// instance share stimulus and are compared each cycle against a behavioural model.
module tb_wb_stage;

   logic        clk = 1'b0;
   logic        rst, in_valid, stall, flush, RegWEn;
   logic [63:0] alu, dataB, pc_4, imm;
   logic [1:0]  WBSel;
   logic [2:0]  funct3;
   logic [2:0]  addr_lo;
   logic [4:0]  rd;

   logic [31:0] wb32;
   logic [4:0]  wb_rd32;
   logic        wb_we32, wb_valid32;
   logic [3:0]  retired32;
   logic [63:0] wb64;
   logic [4:0]  wb_rd64;
   logic        wb_we64, wb_valid64;
   logic [31:0] retired64;

   int checks = 0;
   int errors = 0;

   // Model state: the captured instruction and the two retire counters.
   logic        mValid;
   logic [63:0] mAlu, mData, mPc4, mImm;
   logic [1:0]  mSel;
   logic [2:0]  mF3, mAddr;
   logic [4:0]  mRd;
   logic        mWe;
   logic [3:0]  mRet32;
   logic [31:0] mRet64;

   always #5 clk = ~clk;

   wb_stage #(.XLEN(32), .CNT_W(4)) dut32 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .stall(stall), .flush(flush),
      .alu(alu[31:0]), .dataB(dataB[31:0]), .pc_4(pc_4[31:0]), .imm(imm[31:0]),
      .WBSel(WBSel), .funct3(funct3), .addr_lo(addr_lo[1:0]), .rd(rd), .RegWEn(RegWEn),
      .wb(wb32), .wb_rd(wb_rd32), .wb_we(wb_we32), .wb_valid(wb_valid32), .retired(retired32)
   );

   wb_stage #(.XLEN(64), .CNT_W(32)) dut64 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .stall(stall), .flush(flush),
      .alu(alu), .dataB(dataB), .pc_4(pc_4), .imm(imm),
      .WBSel(WBSel), .funct3(funct3), .addr_lo(addr_lo), .rd(rd), .RegWEn(RegWEn),
      .wb(wb64), .wb_rd(wb_rd64), .wb_we(wb_we64), .wb_valid(wb_valid64), .retired(retired64)
   );

   // Single comparison point: counts every check and reports any mismatch.
   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
      end
   endtask

   // Expected write-back value, derived from access size, lane and extension rules.
   function automatic logic [63:0] expWb(input int xlen);
      int nbytes, size, lane;
      logic [63:0] d, val, mask;
      if (!mValid) return 64'd0;
      case (mSel)
         2'b01: val = mAlu;
         2'b10: val = mPc4;
         2'b11: val = mImm;
         default: begin
            nbytes = xlen / 8;
            size = 1 << mF3[1:0];
            if (size > nbytes) size = nbytes;
            d = (xlen == 32) ? {32'd0, mData[31:0]} : mData;
            lane = ((int'(mAddr) % nbytes) / size) * size;
            mask = (size == 8) ? ~64'd0 : ((64'd1 << (8 * size)) - 64'd1);
            val = (d >> (8 * lane)) & mask;
            if (!mF3[2] && val[8 * size - 1]) val = val | ~mask;
         end
      endcase
      if (xlen == 32) val = val & 64'hFFFF_FFFF;
      return val;
   endfunction

   task automatic modelEdge();
      if (rst) begin
         mValid = 0; mAlu = 0; mData = 0; mPc4 = 0; mImm = 0;
         mSel = 0; mF3 = 0; mAddr = 0; mRd = 0; mWe = 0;
         mRet32 = 0; mRet64 = 0;
      end else begin
         if (mValid && !stall) begin
            mRet32 = mRet32 + 4'd1;
            mRet64 = mRet64 + 32'd1;
         end
         if (flush) mValid = 0;
         else if (!stall) begin
            mValid = in_valid; mAlu = alu; mData = dataB; mPc4 = pc_4; mImm = imm;
            mSel = WBSel; mF3 = funct3; mAddr = addr_lo; mRd = rd; mWe = RegWEn;
         end
      end
   endtask

   task automatic checkModel();
      checkOutput("wb32",       {32'd0, wb32},       expWb(32));
      checkOutput("wb_rd32",    {59'd0, wb_rd32},    mValid ? {59'd0, mRd} : 64'd0);
      checkOutput("wb_we32",    {63'd0, wb_we32},    {63'd0, mValid && mWe && (mRd != 0)});
      checkOutput("wb_valid32", {63'd0, wb_valid32}, {63'd0, mValid});
      checkOutput("retired32",  {60'd0, retired32},  {60'd0, mRet32});
      checkOutput("wb64",       wb64,                expWb(64));
      checkOutput("wb_rd64",    {59'd0, wb_rd64},    mValid ? {59'd0, mRd} : 64'd0);
      checkOutput("wb_we64",    {63'd0, wb_we64},    {63'd0, mValid && mWe && (mRd != 0)});
      checkOutput("wb_valid64", {63'd0, wb_valid64}, {63'd0, mValid});
      checkOutput("retired64",  {32'd0, retired64},  {32'd0, mRet64});
   endtask

   // One clock edge with the currently driven inputs, then compare against the model.
   task automatic applyStimulus();
      modelEdge();
      @(posedge clk);
      #1;
      checkModel();
   endtask

   task automatic setInstr(input logic [1:0] sel, input logic [2:0] f3, input logic [2:0] a,
                           input logic [4:0] r);
      in_valid = 1; stall = 0; flush = 0; RegWEn = 1;
      WBSel = sel; funct3 = f3; addr_lo = a; rd = r;
   endtask

   logic [3:0] savedRet;

   initial begin
      rst = 1; in_valid = 1; stall = 0; flush = 0; RegWEn = 1;
      alu = 64'h11; dataB = 64'h22; pc_4 = 64'h33; imm = 64'h44;
      WBSel = 2'b01; funct3 = 3'b010; addr_lo = 0; rd = 5'd7;
      mValid = 0; mRet32 = 0; mRet64 = 0;

      // Reset held for two cycles with a valid instruction presented.
      repeat (2) begin
         applyStimulus();
         checkOutput("rst_valid", {63'd0, wb_valid32}, 64'd0);
         checkOutput("rst_wb",    {32'd0, wb32},       64'd0);
      end
      rst = 0;
      applyStimulus();
      checkOutput("first_valid", {63'd0, wb_valid32}, 64'd1);
      checkOutput("first_wb",    {32'd0, wb32},       64'h11);

      // Load formats on a 32-bit word.
      dataB = 64'h8899AABB;
      setInstr(2'b00, 3'b000, 3'd2, 5'd5); applyStimulus();
      checkOutput("lb",  {32'd0, wb32}, 64'hFFFFFF99);
      setInstr(2'b00, 3'b100, 3'd2, 5'd5); applyStimulus();
      checkOutput("lbu", {32'd0, wb32}, 64'h00000099);
      setInstr(2'b00, 3'b001, 3'd3, 5'd5); applyStimulus();
      checkOutput("lh",  {32'd0, wb32}, 64'hFFFF8899);
      setInstr(2'b00, 3'b101, 3'd0, 5'd5); applyStimulus();
      checkOutput("lhu", {32'd0, wb32}, 64'h0000AABB);
      setInstr(2'b00, 3'b010, 3'd0, 5'd5); applyStimulus();
      checkOutput("lw",  {32'd0, wb32}, 64'h8899AABB);

      // Source select, then the same with rd=x0.
      alu = 64'd5; pc_4 = 64'h104; imm = 64'h12345000;
      for (int r = 0; r < 2; r++) begin
         for (int s = 1; s < 4; s++) begin
            setInstr(2'(s), 3'b010, 3'd0, (r == 0) ? 5'd3 : 5'd0);
            applyStimulus();
            checkOutput("sel_we", {63'd0, wb_we32}, (r == 0) ? 64'd1 : 64'd0);
         end
      end

      // Stall holds the captured ALU result while the inputs move.
      alu = 64'd7; setInstr(2'b01, 3'b010, 3'd0, 5'd9); applyStimulus();
      savedRet = mRet32;
      stall = 1;
      for (int i = 0; i < 3; i++) begin
         alu = 64'(100 + i); WBSel = 2'(i); rd = 5'(20 + i);
         applyStimulus();
         checkOutput("stall_wb",  {32'd0, wb32},      64'd7);
         checkOutput("stall_ret", {60'd0, retired32}, {60'd0, savedRet});
      end
      stall = 0; applyStimulus();
      checkOutput("release_ret", {60'd0, retired32}, {60'd0, savedRet + 4'd1});

      // Flush overrides stall and in_valid.
      flush = 1; stall = 1; in_valid = 1; applyStimulus();
      checkOutput("flush_valid", {63'd0, wb_valid32}, 64'd0);
      checkOutput("flush_wb",    {32'd0, wb32},       64'd0);
      checkOutput("flush_we",    {63'd0, wb_we32},    64'd0);
      flush = 0; stall = 0;

      // Counter wrap on the 4-bit instance: 17 instructions retire -> 1.
      rst = 1; applyStimulus(); rst = 0;
      setInstr(2'b01, 3'b010, 3'd0, 5'd1);
      repeat (17) applyStimulus();
      in_valid = 0; applyStimulus();
      checkOutput("wrap", {60'd0, retired32}, 64'd1);

      // 64-bit LWU from the upper word.
      dataB = 64'hF000_0000_0000_0000;
      setInstr(2'b00, 3'b110, 3'd4, 5'd4); applyStimulus();
      checkOutput("lwu64", wb64, 64'h0000_0000_F000_0000);

      // Randomised traffic against the model.
      for (int i = 0; i < 400; i++) begin
         rst      = ($urandom_range(0, 49) == 0);
         in_valid = $urandom_range(0, 3) != 0;
         stall    = $urandom_range(0, 3) == 0;
         flush    = $urandom_range(0, 9) == 0;
         RegWEn   = $urandom_range(0, 3) != 0;
         alu   = {$urandom, $urandom};
         dataB = {$urandom, $urandom};
         pc_4  = {$urandom, $urandom};
         imm   = {$urandom, $urandom};
         WBSel   = 2'($urandom);
         funct3  = 3'($urandom);
         addr_lo = 3'($urandom);
         rd      = 5'($urandom_range(0, 7));
         applyStimulus();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/wb_stage.md
# wb_stage

Registered, parametrised write-back stage for the RV core. It sits between the memory stage and the register-file write port, and holds the MEM/WB pipeline register with stall and flush control. It formats load data (byte/half/word/dword with sign or zero extension) and selects the write-back source from four options (memory, ALU, PC+4, immediate). It also drives the register-file write port and counts retired instructions.

## Interface
- XLEN, 32: datapath width; legal values 32 or 64.
- CNT_W, 32: width of retired-instruction counter.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  memory stage presents a valid instruction.
- stall  in  1  hold stage register contents.
- flush  in  1  kill instruction being captured this cycle.
- alu  in  XLEN  ALU result.
- dataB  in  XLEN  raw, naturally aligned memory read word.
- pc_4  in  XLEN  PC+4 of instruction.
- imm  in  XLEN  immediate, used for LUI.
- WBSel  in  2  00 memory, 01 ALU, 10 PC+4, 11 imm.
- funct3  in  3  load type.
- addr_lo  in  log2(XLEN/8)  low bits of load address.
- rd  in  5  destination register.
- RegWEn  in  1  instruction writes rd.
- wb  out  XLEN  write-back data.
- wb_rd  out  5  write-back destination.
- wb_we  out  1  register-file write enable.
- wb_valid  out  1  stage holds a valid instruction.
- retired  out  CNT_W  count of instructions leaving the stage.

## Operation
- Stage register fields: valid, alu, dataB, pc_4, imm, WBSel, funct3, addr_lo, rd, RegWEn.
- Update priority on each edge: rst > flush > stall > load.
  - rst: all fields cleared to 0.
  - flush: valid cleared to 0; other fields don't-care. Flush overrides both stall and in_valid.
  - stall (without flush): all fields hold.
  - Otherwise: all fields load from the inputs, with valid taking in_valid.
- Load formatting is applied to the registered dataB.
  - Byte lane = addr_lo, masked down to access alignment: half clears bit 0, word clears bits [1:0], dword uses lane 0.
  - funct3 000 LB: sign-extend byte. 100 LBU: zero-extend byte.
  - funct3 001 LH: sign-extend half. 101 LHU: zero-extend half.
  - funct3 010 LW: sign-extend word. 110 LWU: zero-extend word.
  - funct3 011 LD: full word.
  - When XLEN=32, funct3 010/011/110 all return the full 32-bit word.
  - funct3 111 returns the raw dataB.
- Source select: WBSel 00 formatted load, 01 alu, 10 pc_4, 11 imm.
- wb is forced to 0 when valid=0.
- wb_we = valid & RegWEn & (rd != 0); writes to x0 are never issued.
- wb_rd is the registered rd when valid=1, otherwise 0.
- wb_valid = valid.
- retired increments by 1 on each edge where valid=1 and stall=0, i.e. the instruction leaves the stage.
  - Flush does not block the increment, because flush acts on the incoming instruction only.
  - The counter wraps modulo 2^CNT_W.

## Timing
- Latency: inputs sampled at edge N appear on wb, wb_rd and wb_we after edge N, for the whole of cycle N+1.
- Outputs are purely combinational from stage registers; there is no input-to-output combinational path.
- Throughput: one instruction per cycle when stall=0.
- Under stall, wb and wb_we remain asserted with identical values every held cycle. The repeated register-file write is idempotent.
- Reset values: wb=0, wb_rd=0, wb_we=0, wb_valid=0, retired=0, effective the cycle after rst is sampled high.
- Reset asserted mid-stall or mid-flush takes priority; the pending instruction is discarded.
- Reset does not depend on the stall or flush levels.

## Test plan
- Reset: drive in_valid=1 and rst=1 for 2 cycles, then release.
  - Required: all outputs 0 throughout; first instruction appears one cycle after release.
- Load formats, XLEN=32, dataB=0x8899AABB, WBSel=00:
  - LB, addr_lo=2 -> wb=0xFFFFFF99.
  - LBU, addr_lo=2 -> wb=0x00000099.
  - LH, addr_lo=3 -> lane masked to 2 -> wb=0xFFFF8899.
  - LHU, addr_lo=0 -> wb=0x0000AABB.
  - LW -> wb=0x8899AABB.
- Source select and x0: alu=5, pc_4=0x104, imm=0x12345000, rd=3, RegWEn=1, WBSel stepped 01/10/11.
  - Required: wb=5 / 0x104 / 0x12345000, wb_we=1 each cycle.
  - Repeat with rd=0: wb_we=0.
- Stall: capture an ALU op with alu=7, then hold stall=1 for 3 cycles while the inputs change.
  - Required: wb stays 7 and retired stays unchanged during the stall.
  - Required: retired increments by exactly 1 on the release edge.
- Flush: assert flush=1 together with stall=1 and in_valid=1.
  - Required: next cycle wb_valid=0, wb=0, wb_we=0.
  - Required: retired increments only if the stage was valid before the flush edge.
- Counter wrap and XLEN=64:
  - CNT_W=4: 17 back-to-back valid instructions -> retired=1.
  - XLEN=64, LWU, addr_lo=4, dataB=0xF0000000_00000000 -> wb=0x00000000_F0000000.
